stage3_execute_unit: RTL and testbench
======================================

Name: stage3_execute_unit

Overview:
- Integer execute unit of the RV32IMC pipeline, between decode/register-read and stage4_memory.
- Its result drives the memory stage's address/ALU-result input.
- Computes RV32I ALU ops and single-cycle RV32M multiplies combinationally.
- RV32M divide/remainder uses an iterative radix-2 restoring divider; the pipeline is stalled until the quotient or remainder is ready.

Parameters:
- XLEN, 32, datapath width (only 32 supported).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  operation in execute is valid.
- flush_i  input  1  kill the current operation (branch mispredict/trap).
- stall_i  input  1  downstream stall (e.g. dmiss_stall); freezes the divider result hand-off.
- op_i  input  5  operation code, encoding below.
- rs1_i  input  XLEN  operand A.
- rs2_i  input  XLEN  operand B.
- result_o  output  XLEN  operation result.
- ex_stall_o  output  1  execute busy; upstream must hold op_i/rs1_i/rs2_i stable.

Behaviour:
- op_i encoding:
  - ALU: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - Multiply: 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU.
  - Divide: 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - 18-31: result 0, no stall.
- Shifts use rs2_i[4:0]. SLT/SLTU produce 0 or 1.
- Multiply: full 64-bit product, combinational. MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32] with signed×signed / signed×unsigned / unsigned×unsigned operands.
- Non-divide ops:
  - result_o is combinational, same cycle.
  - ex_stall_o = 0.
  - result_o = 0 when valid_i = 0.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY: valid_i & divide op & !flush_i. Latch operand magnitudes, signs, op kind; count = 0.
  - IDLE → DONE directly (special cases, result latched at entry):
    - rs2_i = 0: quotient = all ones, remainder = rs1_i.
    - Signed op with rs1_i = 0x80000000 and rs2_i = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - BUSY: one restoring step per cycle, 32 steps (count 0..31). After step 31 → DONE. Apply sign correction:
    - quotient negated if the operand signs differ (signed ops);
    - remainder takes the dividend's sign.
  - DONE: result_o = latched quotient or remainder; ex_stall_o = 0. → IDLE when !stall_i, otherwise hold DONE with result stable.
- ex_stall_o = (IDLE & valid_i & divide op & !flush_i) | BUSY. Low in DONE.
- Latency:
  - Normal divide issued at cycle 0: ex_stall_o high cycles 0..32, result valid cycle 33.
  - Special-case divide: ex_stall_o high cycle 0 only, result cycle 1.
- Upstream holds inputs while ex_stall_o = 1. The divider uses only latched values after IDLE, so input changes during BUSY are ignored.
- flush_i has priority in every state: next state IDLE, count cleared, and ex_stall_o = 0 combinationally in that cycle. flush_i together with a new valid_i divide in IDLE starts nothing.
- stall_i in BUSY does not pause iteration. stall_i only holds DONE.
- Reset (async, any state, including mid-division):
  - state IDLE, count 0, all divider registers 0;
  - ex_stall_o = 0;
  - result_o = 0 (valid_i low) or the combinational value for non-divide ops.
- Division arithmetic is on 32-bit magnitudes with a 33-bit partial remainder. 0x80000000 magnitude must be handled as unsigned 2^31.

Test Plan:
- ALU/mul sweep: ADD 0x7FFFFFFF+1 → 0x80000000; SRA 0x80000000>>4 → 0xF8000000; MULH 0xFFFFFFFF×0xFFFFFFFF → 0; MULHU same → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. All with ex_stall_o = 0.
- DIV -7/2 issued cycle 0 → ex_stall_o high cycles 0..32, result_o = 0xFFFFFFFD at cycle 33. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14, REMU → 2.
- Special cases: DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same → 0. Each with a single stall cycle, result at cycle 1.
- flush_i asserted at cycle 10 of a DIV → ex_stall_o low that cycle, FSM IDLE next cycle. A following ADD 3+4 → 7 with no stall.
- stall_i held high cycles 33..36 after a DIV completes → result_o stable and ex_stall_o low throughout. FSM returns to IDLE the cycle after stall_i drops.
- rst_i pulsed asynchronously at cycle 15 of a DIVU → ex_stall_o falls immediately. A new DIVU 9/3 afterwards → 3 at its cycle 33.

Source files
------------

// File: rtl/stage3_execute_unit.sv
// RV32IM execute: combinational ALU/multiply; 32-step restoring divide (34-cycle issue-to-result, 2 for div-by-0/overflow).
// Holds upstream via ex_stall_o while dividing; stall_i freezes the finished divide result.
module stage3_execute_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] result_o,
  output logic            ex_stall_o
);

  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLL = 5'd2, OP_SLT = 5'd3,
                         OP_SLTU = 5'd4, OP_XOR = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7,
                         OP_OR = 5'd8, OP_AND = 5'd9, OP_MUL = 5'd10, OP_MULH = 5'd11,
                         OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14,
                         OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [4:0]      r_count;
  logic [XLEN-1:0] r_quo, r_dvs, r_rem, r_res;
  logic            r_is_rem, r_neg_q, r_neg_r;

  logic              w_is_div, w_signed_div, w_rem_op, w_a_neg, w_b_neg, w_div0, w_ovf;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_special_res, w_alu;
  logic [XLEN:0]     w_rem_sh, w_sub;
  logic              w_qbit;
  logic [XLEN-1:0]   w_rem_nxt, w_quo_nxt, w_final;
  logic [2*XLEN-1:0] w_ma, w_mb, w_prod;
  logic [4:0]        w_shamt;

  assign w_is_div     = (op_i >= OP_DIV) && (op_i <= OP_REMU);
  assign w_signed_div = (op_i == OP_DIV) || (op_i == OP_REM);
  assign w_rem_op     = (op_i == OP_REM) || (op_i == OP_REMU);
  assign w_a_neg      = w_signed_div & rs1_i[XLEN-1];
  assign w_b_neg      = w_signed_div & rs2_i[XLEN-1];
  assign w_a_mag      = w_a_neg ? -rs1_i : rs1_i;
  assign w_b_mag      = w_b_neg ? -rs2_i : rs2_i;
  assign w_div0       = (rs2_i == '0);
  assign w_ovf        = w_signed_div && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
  assign w_special_res = w_div0 ? (w_rem_op ? rs1_i : '1)
                                : (w_rem_op ? '0 : {1'b1, {(XLEN-1){1'b0}}});

  // Borrow out of the 33-bit subtract is exactly "partial remainder < divisor".
  assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
  assign w_sub     = w_rem_sh - {1'b0, r_dvs};
  assign w_qbit    = ~w_sub[XLEN];
  assign w_rem_nxt = w_qbit ? w_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_qbit};
  assign w_final   = r_is_rem ? (r_neg_r ? -w_rem_nxt : w_rem_nxt)
                              : (r_neg_q ? -w_quo_nxt : w_quo_nxt);

  // One shared multiplier; operand extension selects the signedness variant.
  assign w_ma    = {{XLEN{rs1_i[XLEN-1] & (op_i != OP_MULHU)}}, rs1_i};
  assign w_mb    = {{XLEN{rs2_i[XLEN-1] & (op_i == OP_MULH)}}, rs2_i};
  assign w_prod  = w_ma * w_mb;
  assign w_shamt = rs2_i[4:0];

  always_comb begin
    w_alu = '0;
    case (op_i)
      OP_ADD:    w_alu = rs1_i + rs2_i;
      OP_SUB:    w_alu = rs1_i - rs2_i;
      OP_SLL:    w_alu = rs1_i << w_shamt;
      OP_SLT:    w_alu = {{(XLEN-1){1'b0}}, $signed(rs1_i) < $signed(rs2_i)};
      OP_SLTU:   w_alu = {{(XLEN-1){1'b0}}, rs1_i < rs2_i};
      OP_XOR:    w_alu = rs1_i ^ rs2_i;
      OP_SRL:    w_alu = rs1_i >> w_shamt;
      OP_SRA:    w_alu = $unsigned($signed(rs1_i) >>> w_shamt);
      OP_OR:     w_alu = rs1_i | rs2_i;
      OP_AND:    w_alu = rs1_i & rs2_i;
      OP_MUL:    w_alu = w_prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  w_alu = w_prod[2*XLEN-1:XLEN];
      default:   w_alu = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (valid_i && w_is_div) w_state_nxt = (w_div0 || w_ovf) ? S_DONE : S_BUSY;
      S_BUSY:  if (r_count == 5'd31) w_state_nxt = S_DONE;
      S_DONE:  if (!stall_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_i) w_state_nxt = S_IDLE;
  end

  assign ex_stall_o = !rst_i && !flush_i &&
                      (((r_state == S_IDLE) && valid_i && w_is_div) || (r_state == S_BUSY));
  assign result_o   = (r_state == S_DONE)     ? r_res :
                      (valid_i && !w_is_div)  ? w_alu : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_res    <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (flush_i) begin
        r_count <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (valid_i && w_is_div) begin
            r_count  <= '0;
            r_is_rem <= w_rem_op;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_quo    <= w_a_mag;
            r_dvs    <= w_b_mag;
            r_rem    <= '0;
            r_res    <= w_special_res;
          end
          S_BUSY: begin
            r_quo   <= w_quo_nxt;
            r_rem   <= w_rem_nxt;
            r_count <= r_count + 5'd1;
            if (r_count == 5'd31) r_res <= w_final;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stage3_execute_unit.sv
// Bench for stage3_execute_unit: directed corner cases plus random ops against an arithmetic reference model.
module tb_stage3_execute_unit;

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, flush_i, stall_i;
  logic [4:0]  op_i;
  logic [31:0] rs1_i, rs2_i, result_o;
  logic        ex_stall_o;

  int    n_tests = 0;
  int    n_fail  = 0;
  logic  chk_stall = 1'b0, chk_res = 1'b0;
  logic  exp_stall = 1'b0;
  logic [31:0] exp_res = '0;
  string cname = "";

  stage3_execute_unit #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i), .stall_i(stall_i),
    .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .result_o(result_o), .ex_stall_o(ex_stall_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: plain 64-bit integer arithmetic straight from the instruction definitions.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    r = '0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a << b[4:0];
      5'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  r = (a < b) ? 32'd1 : 32'd0;
      5'd5:  r = a ^ b;
      5'd6:  r = a >> b[4:0];
      5'd7:  begin p = sa >>> b[4:0]; r = p[31:0]; end
      5'd8:  r = a | b;
      5'd9:  r = a & b;
      5'd10: begin p = sa * sb; r = p[31:0]; end
      5'd11: begin p = sa * sb; r = p[63:32]; end
      5'd12: begin p = sa * ub; r = p[63:32]; end
      5'd13: begin p = ua * ub; r = p[63:32]; end
      5'd14: if (b == 0) r = '1; else begin p = sa / sb; r = p[31:0]; end
      5'd15: if (b == 0) r = '1; else begin p = ua / ub; r = p[31:0]; end
      5'd16: if (b == 0) r = a;  else begin p = sa % sb; r = p[31:0]; end
      5'd17: if (b == 0) r = a;  else begin p = ua % ub; r = p[31:0]; end
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(negedge clk_i) begin
    if (chk_stall) begin
      n_tests++;
      if (ex_stall_o !== exp_stall) begin
        n_fail++;
        $display("FAIL %s: ex_stall_o=%b expected %b at %0t", cname, ex_stall_o, exp_stall, $time);
      end
    end
    if (chk_res) begin
      n_tests++;
      if (result_o !== exp_res) begin
        n_fail++;
        $display("FAIL %s: result_o=%h expected %h at %0t", cname, result_o, exp_res, $time);
      end
    end
  end

  task automatic cyc(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic fl, input logic st, input logic cs, input logic es,
                     input logic cr, input logic [31:0] er, input string nm);
    @(posedge clk_i); #1;
    valid_i = v; op_i = op; rs1_i = a; rs2_i = b; flush_i = fl; stall_i = st;
    chk_stall = cs; exp_stall = es; chk_res = cr; exp_res = er; cname = nm;
  endtask

  // One operation from issue to hand-off; hold = cycles stall_i stays high once the result is up.
  task automatic issue(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input logic use_lit, input logic [31:0] lit, input string nm);
    logic [31:0] er;
    logic        is_div, sp;
    int          lat;
    er     = use_lit ? lit : (v ? model(op, a, b) : 32'd0);
    is_div = v && (op >= 5'd14) && (op <= 5'd17);
    if (!is_div) begin
      if (!v || (op >= 5'd14 && op <= 5'd17)) er = 32'd0;
      cyc(v, op, a, b, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, er, nm);
    end else begin
      sp  = (b == 0) || ((op == 5'd14 || op == 5'd16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      lat = sp ? 1 : 33;
      for (int k = 0; k < lat; k++)
        cyc(1'b1, op, a, b, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, {nm, "_busy"});
      for (int h = 0; h <= hold; h++)
        cyc(1'b1, op, a, b, 1'b0, (h < hold), 1'b1, 1'b0, 1'b1, er, nm);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic        v;
    logic [4:0]  op;
    logic [31:0] a, b;
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    op_i = '0; rs1_i = '0; rs2_i = '0;

    cyc(1'b0, 5'd0,  32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, "reset_idle");
    cyc(1'b1, 5'd0,  32'd3, 32'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd7, "reset_add");
    cyc(1'b1, 5'd14, 32'd9, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, "reset_div");
    @(posedge clk_i); #1;
    chk_stall = 1'b0; chk_res = 1'b0; valid_i = 1'b0; rst_i = 1'b0;

    issue(1, 5'd0,  32'h7FFF_FFFF, 32'h1,         0, 1, 32'h8000_0000, "add_ovf");
    issue(1, 5'd7,  32'h8000_0000, 32'd4,         0, 1, 32'hF800_0000, "sra");
    issue(1, 5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'h0000_0000, "mulh");
    issue(1, 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFE, "mulhu");
    issue(1, 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFF, "mulhsu");
    issue(1, 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'h0000_0001, "mul");
    issue(1, 5'd1,  32'h0,         32'h1,         0, 1, 32'hFFFF_FFFF, "sub");
    issue(1, 5'd3,  32'hFFFF_FFFF, 32'h1,         0, 1, 32'h1,         "slt");
    issue(1, 5'd4,  32'hFFFF_FFFF, 32'h1,         0, 1, 32'h0,         "sltu");
    issue(1, 5'd2,  32'h1,         32'h3F,        0, 1, 32'h8000_0000, "sll_shamt5");
    issue(1, 5'd20, 32'h1234,      32'h5678,      0, 1, 32'h0,         "op_unused");
    issue(1, 5'd14, 32'hFFFF_FFF9, 32'd2,         0, 1, 32'hFFFF_FFFD, "div_m7_2");
    issue(1, 5'd16, 32'hFFFF_FFF9, 32'd2,         0, 1, 32'hFFFF_FFFF, "rem_m7_2");
    issue(1, 5'd15, 32'd100,       32'd7,         0, 1, 32'd14,        "divu_100_7");
    issue(1, 5'd17, 32'd100,       32'd7,         0, 1, 32'd2,         "remu_100_7");
    issue(1, 5'd15, 32'd5,         32'd0,         0, 1, 32'hFFFF_FFFF, "divu_by0");
    issue(1, 5'd16, 32'd5,         32'd0,         0, 1, 32'd5,         "rem_by0");
    issue(1, 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h8000_0000, "div_ovf");
    issue(1, 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h0,         "rem_ovf");
    issue(1, 5'd14, 32'h8000_0000, 32'd2,         0, 1, 32'hC000_0000, "div_minint");
    issue(1, 5'd15, 32'h8000_0000, 32'd1,         0, 1, 32'h8000_0000, "divu_2p31");
    issue(1, 5'd17, 32'hFFFF_FFFF, 32'h10,        0, 1, 32'hF,         "remu_big");
    issue(1, 5'd14, 32'd100,       32'hFFFF_FFFD, 4, 1, 32'hFFFF_FFDF, "div_hold");
    issue(1, 5'd0,  32'd3,         32'd4,         0, 1, 32'd7,         "add_after_hold");

    for (int k = 0; k < 10; k++)
      cyc(1'b1, 5'd14, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, "div_pre_flush");
    cyc(1'b1, 5'd14, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, "flush_busy");
    issue(1, 5'd0, 32'd3, 32'd4, 0, 1, 32'd7, "add_after_flush");
    cyc(1'b1, 5'd15, 32'd100, 32'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, "flush_idle");
    issue(1, 5'd0, 32'd3, 32'd4, 0, 1, 32'd7, "add_after_flush_idle");

    for (int k = 0; k < 15; k++)
      cyc(1'b1, 5'd15, 32'd1000, 32'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, "divu_pre_rst");
    @(posedge clk_i); #1;
    cname = "rst_async"; chk_stall = 1'b1; exp_stall = 1'b0; chk_res = 1'b1; exp_res = 32'd0;
    #2 rst_i = 1'b1;
    cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, "rst_hold");
    #2 rst_i = 1'b0;
    issue(1, 5'd15, 32'd9, 32'd3, 0, 1, 32'd3, "divu_after_rst");

    for (int n = 0; n < 60; n++) begin
      v  = ($urandom_range(0, 7) != 0);
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(14, 17));
      a  = pick();
      b  = pick();
      issue(v, op, a, b, $urandom_range(0, 2), 0, 32'd0, "rand_op");
    end

    @(posedge clk_i); #1;
    chk_stall = 1'b0; chk_res = 1'b0; valid_i = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
